// File: rtl/pong_game_ctrl_if.sv
// Pong game sequencer bus: per-frame inputs from the video/ball side and
// the sequencer's control and status outputs.
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               frame_tick;
  logic               start;
  logic [8:0]         ballY;
  logic               paddle_hit;
  logic               ball_en;
  logic               ball_load;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic               game_over;
  logic [2:0]         state;

  // Driver side: supplies frame events and the start button, observes status.
  modport master (
    output frame_tick, start, ballY, paddle_hit,
    input  ball_en, ball_load, score, lives, game_over, state
  );

  // Sequencer side.
  modport slave (
    input  frame_tick, start, ballY, paddle_hit,
    output ball_en, ball_load, score, lives, game_over, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: runs serve / play / miss / game-over, gates the
// per-frame ball update, requests serve reloads, and keeps score and lives.
// All outputs are registers or decodes of the state register.
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30,
  parameter int LIVES        = 3,
  parameter int MISS_Y       = 470,
  parameter int SCORE_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] MISS_LAST  = CNT_W'(MISS_FRAMES - 1);
  localparam logic [8:0]       MISS_Y_C   = 9'(MISS_Y);
  localparam logic [2:0]       LIVES_C    = 3'(LIVES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic               ball_load_q, ball_load_d;
  logic               start_q;
  logic               start_rise;

  assign start_rise = bus.start & ~start_q;

  // State, counters and the serve-reload pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      score_q     <= '0;
      lives_q     <= LIVES_C;
      ball_load_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      ball_load_q <= ball_load_d;
      start_q     <= bus.start;
    end
  end

  // Next-state logic; frame_tick only matters in SERVE/PLAY/MISS, so a tick
  // coinciding with a start press in IDLE/OVER is naturally dropped.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    score_d     = score_q;
    lives_d     = lives_q;
    ball_load_d = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          state_d     = SERVE;
          score_d     = '0;
          lives_d     = LIVES_C;
          frame_cnt_d = '0;
          ball_load_d = 1'b1;
        end
      end
      SERVE: begin
        if (bus.frame_tick) begin
          if (frame_cnt_q == SERVE_LAST) begin
            state_d     = PLAY;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (bus.frame_tick) begin
          if (bus.ballY >= MISS_Y_C) begin
            state_d     = MISS;
            lives_d     = lives_q - 3'd1;
            frame_cnt_d = '0;
          end else if (bus.paddle_hit && (score_q != '1)) begin
            score_d = score_q + 1'b1;
          end
        end
      end
      MISS: begin
        if (bus.frame_tick) begin
          if (frame_cnt_q == MISS_LAST) begin
            if (lives_q == 3'd0) begin
              state_d = OVER;
            end else begin
              state_d     = SERVE;
              frame_cnt_d = '0;
              ball_load_d = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ball_en   = (state_q == PLAY);
  assign bus.game_over = (state_q == OVER);
  assign bus.ball_load = ball_load_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: two instances (8-bit and 2-bit score) share the
// same stimulus and are compared every cycle against a frame-level model.
module tb_pong_game_ctrl;

  localparam int SERVE_F = 60;
  localparam int MISS_F  = 30;
  localparam int LIVES_N = 3;
  localparam int MISS_YV = 470;

  logic clk;
  logic reset;

  pong_game_ctrl_if #(.SCORE_W(8)) ifa ();
  pong_game_ctrl_if #(.SCORE_W(2)) ifb ();

  pong_game_ctrl #(
    .SERVE_FRAMES(SERVE_F), .MISS_FRAMES(MISS_F), .LIVES(LIVES_N),
    .MISS_Y(MISS_YV), .SCORE_W(8)
  ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

  pong_game_ctrl #(
    .SERVE_FRAMES(SERVE_F), .MISS_FRAMES(MISS_F), .LIVES(LIVES_N),
    .MISS_Y(MISS_YV), .SCORE_W(2)
  ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic       st, tk, ph;
  logic [8:0] by;

  always_comb begin
    ifa.start = st; ifa.frame_tick = tk; ifa.ballY = by; ifa.paddle_hit = ph;
    ifb.start = st; ifb.frame_tick = tk; ifb.ballY = by; ifb.paddle_hit = ph;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: game phase (0 idle,1 serve,2 play,3 miss,4 over), frames
  // remaining in the current timed phase, and the two saturating scores.
  int m_mode, m_left, m_score8, m_score2, m_lives;
  bit m_load, m_prev;

  function automatic void model_reset();
    m_mode = 0; m_left = 0; m_score8 = 0; m_score2 = 0;
    m_lives = LIVES_N; m_load = 0; m_prev = 0;
  endfunction

  function automatic void new_game();
    m_mode = 1; m_left = SERVE_F; m_score8 = 0; m_score2 = 0;
    m_lives = LIVES_N; m_load = 1;
  endfunction

  function automatic void model_step();
    bit rise;
    rise   = st && !m_prev;
    m_prev = st;
    m_load = 0;
    case (m_mode)
      0, 4: if (rise) new_game();
      1: if (tk) begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
      2: if (tk) begin
        if (int'(by) >= MISS_YV) begin
          m_lives--; m_mode = 3; m_left = MISS_F;
        end else if (ph) begin
          if (m_score8 < 255) m_score8++;
          if (m_score2 < 3)   m_score2++;
        end
      end
      3: if (tk) begin
        m_left--;
        if (m_left == 0) begin
          if (m_lives == 0) m_mode = 4;
          else begin m_mode = 1; m_left = SERVE_F; m_load = 1; end
        end
      end
      default: m_mode = 0;
    endcase
  endfunction

  task automatic compare_all();
    check("state_a",   int'(ifa.state),     m_mode);
    check("state_b",   int'(ifb.state),     m_mode);
    check("ball_en",   int'(ifa.ball_en),   (m_mode == 2) ? 1 : 0);
    check("ball_load", int'(ifa.ball_load), int'(m_load));
    check("game_over", int'(ifa.game_over), (m_mode == 4) ? 1 : 0);
    check("lives",     int'(ifa.lives),     m_lives);
    check("score8",    int'(ifa.score),     m_score8);
    check("score2",    int'(ifb.score),     m_score2);
  endtask

  // one clock: model advances on the same inputs the DUTs sample
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic frame(input logic [8:0] y, input logic hit);
    tk = 1'b1; by = y; ph = hit;
    cycle();
    tk = 1'b0; ph = $urandom_range(1, 0) != 0; by = 9'($urandom_range(511, 0));
    repeat ($urandom_range(2, 0)) cycle();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, int'(ifa.state), 0);
    check({tag, "_load"},  int'(ifa.ball_load), 0);
    check({tag, "_en"},    int'(ifa.ball_en), 0);
    check({tag, "_over"},  int'(ifa.game_over), 0);
    check({tag, "_lives"}, int'(ifa.lives), LIVES_N);
    check({tag, "_score"}, int'(ifa.score), 0);
    check({tag, "_scoreb"}, int'(ifb.score), 0);
  endtask

  // asynchronous reset pulse away from the clock edge; outputs must clear at once
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    m_prev = 1'b0;
  endtask

  task automatic miss_window();
    frame(9'($urandom_range(511, MISS_YV)), 1'b1);
    repeat (MISS_F) frame(9'($urandom_range(MISS_YV - 1, 0)), 1'b0);
  endtask

  initial begin
    reset = 1'b1; st = 1'b0; tk = 1'b0; ph = 1'b0; by = '0;
    model_reset();
    #12;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // start press, frame tick on the same cycle must not count
    st = 1'b1; tk = 1'b1;
    cycle();
    st = 1'b0; tk = 1'b0;
    cycle();
    repeat (SERVE_F) frame(9'($urandom_range(MISS_YV - 1, 0)), 1'b0);

    // hits in play
    repeat (5) frame(9'($urandom_range(MISS_YV - 1, 0)), 1'b1);

    // miss with simultaneous hit, then serve reload; two more misses end the game
    miss_window();
    repeat (SERVE_F) frame(9'd100, 1'b0);
    repeat (3) frame(9'd200, 1'b1);
    miss_window();
    repeat (SERVE_F) frame(9'd100, 1'b0);
    frame(9'd469, 1'b1);
    frame(9'($urandom_range(511, MISS_YV)), 1'b0);
    st = 1'b1;  // pressed during the final miss window and held into OVER
    repeat (MISS_F) frame(9'd10, 1'b0);
    repeat (10) cycle();
    st = 1'b0;
    cycle();
    st = 1'b1;
    cycle();
    st = 1'b0;
    repeat (SERVE_F) frame(9'd50, 1'b0);
    repeat (2) frame(9'd60, 1'b1);

    // reset in the middle of play
    async_reset("midplay");
    repeat (3) cycle();
    st = 1'b1;
    cycle();
    st = 1'b0;

    // randomized play
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(19, 0) == 0) st = ~st;
      tk = ($urandom_range(2, 0) == 0);
      if ($urandom_range(7, 0) == 0) by = 9'($urandom_range(511, MISS_YV));
      else                           by = 9'($urandom_range(MISS_YV - 1, 0));
      ph = ($urandom_range(1, 0) != 0);
      if ($urandom_range(2999, 0) == 0) begin
        tk = 1'b0;
        async_reset("rnd");
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
